// File: rtl/pc_sequencer.sv
// Program-counter sequencer with one branch delay slot, register-jump alignment check
// and a halt state entered by jumping to address zero.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  pc_sel,
  input  logic        is_true,
  input  logic [31:0] instr_readdata,
  input  logic [31:0] reg_rs_data,
  output logic [31:0] instr_address,
  output logic [31:0] link_addr,
  output logic        active,
  output logic        in_delay_slot,
  output logic        addr_error
);

  typedef enum logic [1:0] {StRun, StSlot, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] reg_tgt;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + {{14{instr_readdata[15]}}, instr_readdata[15:0], 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
  assign reg_tgt    = {reg_rs_data[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    addr_err_d = addr_err_q;
    if (clk_enable) begin
      unique case (state_q)
        StRun: begin
          pc_d = pc_plus4;
          unique case (pc_sel)
            2'b01: begin
              if (is_true) begin
                target_d = branch_tgt;
                state_d  = StSlot;
              end
            end
            2'b10: begin
              target_d = jump_tgt;
              state_d  = StSlot;
            end
            2'b11: begin
              target_d = reg_tgt;
              state_d  = StSlot;
              if (reg_rs_data[1:0] != 2'b00) addr_err_d = 1'b1;
            end
            default: ;
          endcase
        end
        StSlot: begin
          // Transfers decoded in the delay slot are dropped on purpose.
          pc_d    = target_q;
          state_d = (target_q == 32'd0) ? StHalted : StRun;
        end
        StHalted: pc_d = 32'd0;
        default: begin
          pc_d    = 32'd0;
          state_d = StHalted;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_VECTOR;
      target_q   <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign instr_address = pc_q;
  assign link_addr     = pc_q + 32'd8;
  assign active        = (state_q != StHalted);
  assign in_delay_slot = (state_q == StSlot);
  assign addr_error    = addr_err_q;

endmodule
